// File: rtl/sd_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : sd_cic_decimator
// Purpose  : sinc3 CIC decimator for a 1-bit sigma-delta stream, with an
//            optional boxcar average (enabled by macro SD_AVG_FILTER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module sd_cic_decimator #(
   parameter int W        = 16,
   parameter int DECIM    = 32,
   parameter int AVG_LOG2 = 5
) (
   input  logic         c,
   input  logic         rst,
   input  logic         mod_bit,
   input  logic         invert,
   output logic [W-1:0] raw_d,
   output logic         raw_dv,
   output logic [W-1:0] d,
   output logic         dv
);

   localparam int          CNT_W     = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [W-1:0] c_inv_ref = W'(32767);

   logic             r_mod_s1, r_mod_s2;
   logic             r_inv_s1, r_inv_s2;
   logic [W-1:0]     r_i0, r_i1, r_i2;
   logic [CNT_W-1:0] r_dec_cnt;
   logic             r_load;
   logic [W-1:0]     r_decim, r_dl0, r_dl1, r_dl2;
   logic             w_dec_match;
   logic [W-1:0]     w_d1, w_d2, w_diff2;

   assign w_dec_match = (r_dec_cnt == CNT_W'(DECIM - 1));

   // Comb section: three cascaded first differences at the decimated rate
   assign w_d1    = r_decim - r_dl0;
   assign w_d2    = w_d1 - r_dl1;
   assign w_diff2 = w_d2 - r_dl2;

   always_ff @(posedge c) begin
      if (rst) begin
         r_mod_s1  <= 1'b0;
         r_mod_s2  <= 1'b0;
         r_inv_s1  <= 1'b0;
         r_inv_s2  <= 1'b0;
         r_i0      <= '0;
         r_i1      <= '0;
         r_i2      <= '0;
         r_dec_cnt <= '0;
         r_load    <= 1'b0;
         r_decim   <= '0;
         r_dl0     <= '0;
         r_dl1     <= '0;
         r_dl2     <= '0;
         raw_d     <= '0;
         raw_dv    <= 1'b0;
      end else begin
         r_mod_s1  <= mod_bit;
         r_mod_s2  <= r_mod_s1;
         r_inv_s1  <= invert;
         r_inv_s2  <= r_inv_s1;
         r_i0      <= r_i0 + W'(r_mod_s2);
         r_i1      <= r_i1 + r_i0;
         r_i2      <= r_i2 + r_i1;
         r_dec_cnt <= w_dec_match ? '0 : r_dec_cnt + 1'b1;
         r_load    <= w_dec_match;
         if (w_dec_match) begin
            r_decim <= r_i2;
            r_dl0   <= r_decim;
            r_dl1   <= w_d1;
            r_dl2   <= w_d2;
         end
         raw_dv <= r_load;
         if (r_load) begin
            raw_d <= r_inv_s2 ? (c_inv_ref - w_diff2) : w_diff2;
         end
      end
   end

`ifdef SD_AVG_FILTER_EN
   localparam int ACC_W = W + AVG_LOG2 + 1;

   logic [ACC_W-1:0]    r_acc;
   logic [AVG_LOG2-1:0] r_avg_cnt;
   logic [ACC_W-1:0]    w_sum;

   assign w_sum = r_acc + ACC_W'(raw_d);

   always_ff @(posedge c) begin
      if (rst) begin
         r_acc     <= '0;
         r_avg_cnt <= '0;
         d         <= '0;
         dv        <= 1'b0;
      end else begin
         dv <= 1'b0;
         if (raw_dv) begin
            // All-ones count marks the last sample of the block
            if (&r_avg_cnt) begin
               d         <= W'(w_sum >> AVG_LOG2);
               dv        <= 1'b1;
               r_acc     <= '0;
               r_avg_cnt <= '0;
            end else begin
               r_acc     <= w_sum;
               r_avg_cnt <= r_avg_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign d  = raw_d;
   assign dv = raw_dv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cic_decimator
// Purpose  : directed, table-driven bench for sd_cic_decimator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cic_decimator;

   localparam int W     = 16;
   localparam int DECIM = 32;

   logic         c = 1'b0;
   logic         rst;
   logic         mod_bit;
   logic         invert;
   logic [W-1:0] raw_d;
   logic         raw_dv;
   logic [W-1:0] d;
   logic         dv;

   int n_tests = 0;
   int n_fail  = 0;
   int mode    = 0;   // 0: constant 0, 1: constant 1, 2: toggle every cycle

   always #5 c = ~c;

   sd_cic_decimator #(.W(W), .DECIM(DECIM), .AVG_LOG2(5)) dut (
      .c      (c),
      .rst    (rst),
      .mod_bit(mod_bit),
      .invert (invert),
      .raw_d  (raw_d),
      .raw_dv (raw_dv),
      .d      (d),
      .dv     (dv)
   );

   typedef struct {
      int          mode;
      logic        inv;
      int          idx;
      logic [15:0] exp;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge c);
      #1;
      if (mode == 2) mod_bit = ~mod_bit;
   endtask

   task automatic do_reset(input int m, input logic inv);
      mode    = m;
      mod_bit = (m == 1);
      invert  = inv;
      rst     = 1'b1;
      tick();
      tick();
      rst     = 1'b0;
   endtask

   task automatic wait_strobes(input int n, input int budget, output bit ok);
      int seen;
      int cyc;
      seen = 0;
      cyc  = 0;
      ok   = 1'b0;
      while (cyc < budget && !ok) begin
         tick();
         cyc++;
         if (raw_dv) begin
            seen++;
            if (seen == n) ok = 1'b1;
         end
      end
   endtask

   task automatic count_strobes(input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (raw_dv) cnt++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int cnt;
      rst     = 1'b1;
      mod_bit = 1'b0;
      invert  = 1'b0;

      // Sinc3 words for an all-ones input: third differences of C(32m-3,3)
      vecs[0]  = '{0, 1'b0, 1, 16'h0000};
      vecs[1]  = '{0, 1'b0, 5, 16'h0000};
      vecs[2]  = '{1, 1'b0, 1, 16'h0E46};
      vecs[3]  = '{1, 1'b0, 2, 16'h61C4};
      vecs[4]  = '{1, 1'b0, 3, 16'h7FF6};
      vecs[5]  = '{1, 1'b0, 4, 16'h8000};
      vecs[6]  = '{1, 1'b0, 6, 16'h8000};
      vecs[7]  = '{2, 1'b0, 4, 16'h4000};
      vecs[8]  = '{2, 1'b0, 6, 16'h4000};
      vecs[9]  = '{0, 1'b1, 4, 16'h7FFF};
      vecs[10] = '{1, 1'b1, 4, 16'hFFFF};

      // Reset state
      do_reset(1, 1'b0);
      check("reset_raw_d",  raw_d,  16'h0000);
      check("reset_raw_dv", raw_dv, 1'b0);
      check("reset_d",      d,      16'h0000);
      check("reset_dv",     dv,     1'b0);

      // Latency, strobe width and spacing
      count_strobes(32, cnt);
      check("no_strobe_first_32", cnt, 0);
      tick();
      check("first_strobe_cycle33", raw_dv, 1'b1);
      check("first_word", raw_d, 16'h0E46);
      tick();
      check("strobe_width_1", raw_dv, 1'b0);
      count_strobes(30, cnt);
      check("no_strobe_gap", cnt, 0);
      tick();
      check("second_strobe_cycle65", raw_dv, 1'b1);

      // Table of settled and transient words
      for (int i = 0; i < NV; i++) begin
         do_reset(vecs[i].mode, vecs[i].inv);
         wait_strobes(vecs[i].idx, vecs[i].idx * DECIM + 40, ok);
         check($sformatf("vec%0d_strobe", i), ok, 1'b1);
         check($sformatf("vec%0d_raw_d", i), raw_d, vecs[i].exp);
`ifndef SD_AVG_FILTER_EN
         check($sformatf("vec%0d_d", i), d, vecs[i].exp);
         check($sformatf("vec%0d_dv", i), dv, 1'b1);
`endif
      end

      // Reset mid-word aborts the pending word
      do_reset(1, 1'b0);
      for (int k = 0; k < 100; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_raw_d",  raw_d,  16'h0000);
      check("midrst_raw_dv", raw_dv, 1'b0);
      check("midrst_d",      d,      16'h0000);
      check("midrst_dv",     dv,     1'b0);
      count_strobes(32, cnt);
      check("midrst_quiet_32", cnt, 0);
      tick();
      check("midrst_strobe_33", raw_dv, 1'b1);
      check("midrst_word", raw_d, 16'h0E46);

`ifdef SD_AVG_FILTER_EN
      begin
         int  nraw;
         int  ndv;
         bit  prev_raw;
         nraw     = 0;
         ndv      = 0;
         prev_raw = 1'b0;
         do_reset(2, 1'b0);
         for (int k = 0; k < 2300 && ndv < 2; k++) begin
            tick();
            if (dv) begin
               ndv++;
               check("avg_dv_after_raw_dv", prev_raw, 1'b1);
               check("avg_dv_raw_count", nraw, ndv * 32);
               if (ndv == 2) check("avg_second_d", d, 16'h4000);
            end
            if (raw_dv) begin
               nraw++;
               if (nraw == 31) check("avg_d_zero_before_first", d, 16'h0000);
            end
            prev_raw = raw_dv;
         end
         check("avg_two_dv_seen", ndv, 2);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
